// File: rtl/enigma_pkg.sv
// enigma_pkg: shared scan-code constants, letter count, decoder FSM encoding and index-to-one-hot helper
package enigma_pkg;
   localparam logic [7:0] SC_BREAK    = 8'hF0;
   localparam logic [7:0] SC_EXT      = 8'hE0;
   localparam int         NUM_LETTERS = 26;
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BRK     = 2'd1,
      ST_EXT     = 2'd2,
      ST_EXT_BRK = 2'd3
   } dec_state_e;
   function automatic logic [NUM_LETTERS-1:0] idx_to_onehot(input logic [4:0] idx);
      return NUM_LETTERS'(1) << idx;
   endfunction
endpackage

// File: rtl/scancode_lut.sv
// scancode_lut: maps a PS/2 set-2 byte to a letter index A=0..Z=25
//   code_i      : raw scan-code byte
//   is_letter_o : byte is one of the 26 letter make codes
//   idx_o       : letter index (0 when not a letter)
module scancode_lut (
   input  logic [7:0] code_i,
   output logic       is_letter_o,
   output logic [4:0] idx_o
);
   always_comb begin
      is_letter_o = 1'b1;
      idx_o       = 5'd0;
      case (code_i)
         8'h1C: idx_o = 5'd0;
         8'h32: idx_o = 5'd1;
         8'h21: idx_o = 5'd2;
         8'h23: idx_o = 5'd3;
         8'h24: idx_o = 5'd4;
         8'h2B: idx_o = 5'd5;
         8'h34: idx_o = 5'd6;
         8'h33: idx_o = 5'd7;
         8'h43: idx_o = 5'd8;
         8'h3B: idx_o = 5'd9;
         8'h42: idx_o = 5'd10;
         8'h4B: idx_o = 5'd11;
         8'h3A: idx_o = 5'd12;
         8'h31: idx_o = 5'd13;
         8'h44: idx_o = 5'd14;
         8'h4D: idx_o = 5'd15;
         8'h15: idx_o = 5'd16;
         8'h2D: idx_o = 5'd17;
         8'h1B: idx_o = 5'd18;
         8'h2C: idx_o = 5'd19;
         8'h3C: idx_o = 5'd20;
         8'h2A: idx_o = 5'd21;
         8'h1D: idx_o = 5'd22;
         8'h22: idx_o = 5'd23;
         8'h35: idx_o = 5'd24;
         8'h1A: idx_o = 5'd25;
         default: is_letter_o = 1'b0;
      endcase
   end
endmodule

// File: rtl/ps2_letter_decoder.sv
// ps2_letter_decoder: PS/2 set-2 byte stream to registered one-hot letter with press strobe
//   CLOCK_50   : system clock
//   reset      : asynchronous active-low reset
//   scan_code  : received byte, qualified by scan_valid
//   scan_valid : one-cycle pulse per byte
//   letter     : one-hot last accepted letter (held across release)
//   letter_idx : binary index of letter
//   key_strobe : one-cycle pulse per accepted press
//   key_held   : last accepted letter not yet released
//   bad_code   : one-cycle pulse on an unknown make byte
module ps2_letter_decoder #(
   parameter int NUM_LETTERS = 26
) (
   input  logic                   CLOCK_50,
   input  logic                   reset,
   input  logic [7:0]             scan_code,
   input  logic                   scan_valid,
   output logic [NUM_LETTERS-1:0] letter,
   output logic [4:0]             letter_idx,
   output logic                   key_strobe,
   output logic                   key_held,
   output logic                   bad_code
);
   import enigma_pkg::dec_state_e;
   import enigma_pkg::ST_IDLE;
   import enigma_pkg::ST_BRK;
   import enigma_pkg::ST_EXT;
   import enigma_pkg::ST_EXT_BRK;
   import enigma_pkg::SC_BREAK;
   import enigma_pkg::SC_EXT;
   import enigma_pkg::idx_to_onehot;
   dec_state_e             state_q, state_d;
   logic [NUM_LETTERS-1:0] letter_q, letter_d;
   logic [4:0]             idx_q, idx_d;
   logic                   strobe_q, strobe_d;
   logic                   held_q, held_d;
   logic                   bad_q, bad_d;
   logic                   is_letter;
   logic [4:0]             lut_idx;
   logic                   same_key;
   scancode_lut u_lut (
      .code_i      (scan_code),
      .is_letter_o (is_letter),
      .idx_o       (lut_idx)
   );
   // the byte names the key that is currently down
   assign same_key = held_q && is_letter && (idx_q == lut_idx);
   always_comb begin
      state_d  = state_q;
      letter_d = letter_q;
      idx_d    = idx_q;
      held_d   = held_q;
      strobe_d = 1'b0;
      bad_d    = 1'b0;
      if (scan_valid) begin
         case (state_q)
            ST_IDLE: begin
               if (scan_code == SC_BREAK) state_d = ST_BRK;
               else if (scan_code == SC_EXT) state_d = ST_EXT;
               else if (is_letter) begin
                  // typematic repeat of the held key leaves everything untouched
                  if (!same_key) begin
                     letter_d = idx_to_onehot(lut_idx);
                     idx_d    = lut_idx;
                     strobe_d = 1'b1;
                     held_d   = 1'b1;
                  end
               end else bad_d = 1'b1;
            end
            ST_BRK: begin
               held_d  = same_key ? 1'b0 : held_q;
               state_d = ST_IDLE;
            end
            ST_EXT:  state_d = (scan_code == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         letter_q <= '0;
         idx_q    <= '0;
         strobe_q <= 1'b0;
         held_q   <= 1'b0;
         bad_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         letter_q <= letter_d;
         idx_q    <= idx_d;
         strobe_q <= strobe_d;
         held_q   <= held_d;
         bad_q    <= bad_d;
      end
   end
   assign letter     = letter_q;
   assign letter_idx = idx_q;
   assign key_strobe = strobe_q;
   assign key_held   = held_q;
   assign bad_code   = bad_q;
endmodule

// File: tb/tb_ps2_letter_decoder.sv
// tb_ps2_letter_decoder: directed scoreboard bench for ps2_letter_decoder
module tb_ps2_letter_decoder;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [7:0]  scan_code = 8'h00;
   logic        scan_valid = 1'b0;
   logic [25:0] letter;
   logic [4:0]  letter_idx;
   logic        key_strobe, key_held, bad_code;
   int          checks = 0;
   int          passes = 0;
   int          cyc = 0;
   typedef struct {
      int          kind;
      logic [25:0] l;
      logic [4:0]  i;
      int          c;
   } ev_t;
   ev_t q[$];
   ps2_letter_decoder dut (
      .CLOCK_50   (clk),
      .reset      (reset),
      .scan_code  (scan_code),
      .scan_valid (scan_valid),
      .letter     (letter),
      .letter_idx (letter_idx),
      .key_strobe (key_strobe),
      .key_held   (key_held),
      .bad_code   (bad_code)
   );
   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a === e) passes++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
   endtask
   // kind: 0 no event, 1 strobe, 2 bad_code; the event shows one cycle after issue
   task automatic put(input logic [7:0] b, input int kind = 0, input logic [25:0] l = '0, input logic [4:0] i = '0);
      ev_t e;
      if (kind != 0) begin
         e.kind = kind;
         e.l    = l;
         e.i    = i;
         e.c    = cyc + 1;
         q.push_back(e);
      end
      scan_code  = b;
      scan_valid = 1'b1;
      @(negedge clk);
      scan_valid = 1'b0;
   endtask
   task automatic idle(input int n = 1);
      scan_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask
   always @(negedge clk) begin
      if (reset) begin
         if (key_strobe && bad_code) chk("strobe_bad_exclusive", 32'd1, 32'd0);
         if (key_strobe || bad_code) begin
            if (q.size() == 0) chk("unexpected_event", 32'd1, 32'd0);
            else begin
               ev_t e;
               e = q.pop_front();
               chk("event_kind", bad_code ? 32'd2 : 32'd1, 32'(e.kind));
               chk("event_letter", 32'(letter), 32'(e.l));
               chk("event_idx", 32'(letter_idx), 32'(e.i));
               chk("event_cycle", 32'(cyc), 32'(e.c));
            end
         end
      end
   end
   initial begin
      repeat (3) @(negedge clk);
      chk("reset_letter", 32'(letter), 32'd0);
      chk("reset_idx", 32'(letter_idx), 32'd0);
      chk("reset_strobe", 32'(key_strobe), 32'd0);
      chk("reset_held", 32'(key_held), 32'd0);
      chk("reset_bad", 32'(bad_code), 32'd0);
      reset = 1'b1;
      idle(2);
      put(8'h1C, 1, 26'h1, 5'd0);
      chk("a_held", 32'(key_held), 32'd1);
      idle();
      chk("a_strobe_drop", 32'(key_strobe), 32'd0);
      put(8'hF0);
      put(8'h1C);
      chk("a_released", 32'(key_held), 32'd0);
      chk("a_letter_kept", 32'(letter), 32'h1);
      idle(2);
      put(8'h1A, 1, 26'h2000000, 5'd25);
      put(8'h1A);
      put(8'h1A);
      chk("z_held_repeat", 32'(key_held), 32'd1);
      put(8'hF0);
      chk("z_held_f0", 32'(key_held), 32'd1);
      put(8'h1A);
      chk("z_released", 32'(key_held), 32'd0);
      chk("z_letter", 32'(letter), 32'h2000000);
      chk("z_idx", 32'(letter_idx), 32'd25);
      idle(2);
      put(8'h1C, 1, 26'h1, 5'd0);
      put(8'h32, 1, 26'h2, 5'd1);
      put(8'hF0);
      put(8'h1C);
      chk("ov_still_held", 32'(key_held), 32'd1);
      put(8'hF0);
      put(8'h32);
      chk("ov_released", 32'(key_held), 32'd0);
      chk("ov_letter", 32'(letter), 32'h2);
      idle(2);
      put(8'hE0);
      put(8'h75);
      put(8'hE0);
      put(8'hF0);
      put(8'h75);
      put(8'h76, 2, 26'h2, 5'd1);
      chk("ext_letter", 32'(letter), 32'h2);
      chk("ext_held", 32'(key_held), 32'd0);
      idle(2);
      put(8'h21, 1, 26'h4, 5'd2);
      put(8'hF0);
      put(8'h21);
      put(8'h23, 1, 26'h8, 5'd3);
      put(8'h24, 1, 26'h10, 5'd4);
      chk("b2b_idx", 32'(letter_idx), 32'd4);
      idle(2);
      put(8'hF0);
      reset = 1'b0;
      idle();
      chk("rst_mid_letter", 32'(letter), 32'd0);
      reset = 1'b1;
      idle();
      put(8'h2B, 1, 26'h20, 5'd5);
      chk("rst_mid_held", 32'(key_held), 32'd1);
      for (int k = 0; k < 20 && q.size() != 0; k++) idle();
      chk("events_outstanding", 32'(q.size()), 32'd0);
      idle(2);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
